// File: rtl/vlsu_pkg.sv
// Shared VLSU load-path types: per-beat descriptor for the load data controller
// and the burst record buffered between AR issue and R-beat accounting.
package vlsu_pkg;
  localparam int unsigned NrLanes      = 4;
  localparam int unsigned DefAxiDataW  = 128;
  localparam int unsigned DefAxiAddrW  = 64;
  localparam int unsigned NbAddrW      = DefAxiAddrW + 1;
  localparam int unsigned busNibbles   = DefAxiDataW / 4;
  localparam int unsigned busNSize     = $clog2(busNibbles);
  localparam int unsigned PageNibbles  = 8192;

  typedef struct packed {
    logic [NbAddrW-1:0]  addr;
    logic [busNSize:0]   lbN;
    logic [7:0]          rmnBeat;
    logic                isHead;
    logic                isFinalTxn;
  } txn_ctrl_t;

  typedef struct packed {
    logic [NbAddrW-1:0]  addr;
    logic [7:0]          len;
    logic [busNSize:0]   lbN;
    logic                isFinal;
  } ld_txn_info_t;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} ld_state_e;
endpackage

// File: rtl/QueueFlow.sv
// Small circular FIFO; a pop and a push in the same cycle are allowed even when
// full, with the pop taking effect first.
module QueueFlow #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  output logic full_o,
  input  logic pop_i,
  output T     data_o,
  output logic empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wr, r_rd;
  logic [PW:0]    r_cnt;
  logic           w_pop, w_push;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == (PW+1)'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt_ptr(r_wr);
      if (w_pop)  r_rd <= nxt_ptr(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end
endmodule

// File: rtl/load_txn_gen.sv
// Splits one sequential nibble-addressed load into 4 KiB/max-length-safe AXI INCR
// bursts and emits one txn_ctrl descriptor per expected R beat.
module load_txn_gen #(
  parameter int unsigned AxiDataWidth = vlsu_pkg::DefAxiDataW,
  parameter int unsigned AxiAddrWidth = vlsu_pkg::DefAxiAddrW,
  parameter int unsigned ReqLenWidth  = 32,
  parameter int unsigned MaxBurstLen  = 256,
  parameter int unsigned TxnInfoDepth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [vlsu_pkg::NbAddrW-1:0]  req_nb_addr_i,
  input  logic [ReqLenWidth-1:0]        req_nb_len_i,
  output logic                          axi_ar_valid_o,
  input  logic                          axi_ar_ready_i,
  output logic [AxiAddrWidth-1:0]       axi_ar_addr_o,
  output logic [7:0]                    axi_ar_len_o,
  output logic [2:0]                    axi_ar_size_o,
  output logic [1:0]                    axi_ar_burst_o,
  output logic                          txn_ctrl_valid_o,
  input  logic                          txn_ctrl_ready_i,
  output vlsu_pkg::txn_ctrl_t           txn_ctrl_o
);
  import vlsu_pkg::*;

  localparam int unsigned NW = NbAddrW;
  localparam int unsigned LbW = busNSize + 1;
  localparam logic [NW-1:0] BusMask  = NW'(busNibbles - 1);
  localparam logic [NW-1:0] PageMask = NW'(PageNibbles - 1);
  localparam logic [NW-1:0] MaxSpan  = NW'(MaxBurstLen * busNibbles);

  ld_state_e        r_state, w_state_nxt;
  logic [NW-1:0]    r_cur, r_end, r_be;
  logic [7:0]       r_len;
  logic [LbW-1:0]   r_lbn;
  logic             r_fin;
  logic             w_accept, w_push, w_pop, w_full, w_empty, w_ar_valid;
  logic [NW-1:0]    w_cur_al, w_page_end, w_max_end, w_be, w_span, w_be_m1;
  logic [7:0]       w_beats_m1, w_rmn, r_beat_cnt;
  logic [LbW-1:0]   w_lbn;
  ld_txn_info_t     w_push_info, w_head;

  assign w_accept = (r_state == S_IDLE) && req_valid_i && (req_nb_len_i != '0);

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    w_ar_valid  = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept) w_state_nxt = S_CALC;
      end
      S_CALC: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_ar_valid = !w_full;
        if (w_ar_valid && axi_ar_ready_i) begin
          w_push      = 1'b1;
          w_state_nxt = r_fin ? S_IDLE : S_CALC;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Burst end is the nearest of request end, page end and max-length end.
  always_comb begin
    w_cur_al   = r_cur & ~BusMask;
    w_page_end = (r_cur & ~PageMask) + NW'(PageNibbles);
    w_max_end  = w_cur_al + MaxSpan;
    w_be       = r_end;
    if (w_page_end < w_be) w_be = w_page_end;
    if (w_max_end < w_be)  w_be = w_max_end;
    w_span     = (w_be - w_cur_al + BusMask) >> busNSize;
    w_beats_m1 = 8'(w_span - NW'(1));
    w_be_m1    = w_be - NW'(1);
    w_lbn      = LbW'(w_be_m1 & BusMask) + LbW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_cur <= req_nb_addr_i;
      r_end <= req_nb_addr_i + NW'(req_nb_len_i);
    end else if (r_state == S_CALC) begin
      r_be  <= w_be;
      r_len <= w_beats_m1;
      r_lbn <= w_lbn;
      r_fin <= (w_be == r_end);
    end else if (w_push) begin
      r_cur <= r_be;
    end
  end

  assign axi_ar_valid_o = w_ar_valid;
  assign axi_ar_addr_o  = AxiAddrWidth'(r_cur >> 1);
  assign axi_ar_len_o   = r_len;
  assign axi_ar_size_o  = 3'($clog2(AxiDataWidth / 8));
  assign axi_ar_burst_o = 2'b01;

  assign w_push_info = '{addr: r_cur, len: r_len, lbN: r_lbn, isFinal: r_fin};

  QueueFlow #(.T(ld_txn_info_t), .DEPTH(TxnInfoDepth)) u_info_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_push_info),
    .full_o  (w_full),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .empty_o (w_empty)
  );

  assign txn_ctrl_valid_o = !w_empty;
  assign w_rmn            = w_head.len - r_beat_cnt;
  assign w_pop            = txn_ctrl_valid_o && txn_ctrl_ready_i && (w_rmn == '0);

  assign txn_ctrl_o = '{addr: w_head.addr, lbN: w_head.lbN, rmnBeat: w_rmn,
                        isHead: (r_beat_cnt == '0), isFinalTxn: w_head.isFinal};

  always_ff @(posedge clk_i) begin
    if (rst_i)                                      r_beat_cnt <= '0;
    else if (txn_ctrl_valid_o && txn_ctrl_ready_i)  r_beat_cnt <= w_pop ? 8'd0 : r_beat_cnt + 8'd1;
  end
endmodule
